// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_B = 3'd1,
        RUN    = 3'd2,
        FIXUP  = 3'd3,
        OUT_LO = 3'd4,
        OUT_HI = 3'd5
    } state_t;

    // Which product word the output register loads on the next edge.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_LO   = 2'd1,
        SEL_HI   = 2'd2
    } out_sel_t;

    // Width of the RUN-cycle counter; it never needs to hold more than WIDTH-1.
    function automatic int cnt_width(input int width);
        int w;
        if (width <= 2) begin
            w = 1;
        end else begin
            w = $clog2(width);
        end
        return w;
    endfunction

endpackage

// File: rtl/seq_mult_bus_if.sv
// Z-bus and handshake bundle between the multiplier and its bus master.
interface seq_mult_bus_if #(
    parameter int WIDTH = 32
) ();

    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] z_in;
    logic [WIDTH-1:0] z_out;
    logic             z_oe;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;

    modport master (
        output start, signed_mode, z_in,
        input  z_out, z_oe, a, b, busy, done
    );

    modport slave (
        input  start, signed_mode, z_in,
        output z_out, z_oe, a, b, busy, done
    );

endinterface

// File: rtl/seq_mult_fsm.sv
// Sequencer for the shift-add multiplier: state, RUN counter and early-exit test.
module seq_mult_fsm
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] b,
    output logic             load_a,
    output logic             load_b,
    output logic             add_en,
    output logic             fix_en,
    output out_sel_t         out_sel,
    output logic             busy,
    output logic [CNT_W-1:0] cnt
);

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             last_s;

    // RUN ends once the remaining multiplier bits are all zero or the top bit has been consumed.
    always_comb begin
        last_s = (b[WIDTH-1:1] == {(WIDTH-1){1'b0}}) || (cnt_r == CNT_W'(WIDTH - 1));
    end

    // Next-state and per-state datapath strobes.
    always_comb begin
        state_next_s = state_r;
        load_a       = 1'b0;
        load_b       = 1'b0;
        add_en       = 1'b0;
        fix_en       = 1'b0;
        out_sel      = SEL_NONE;
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_a       = 1'b1;
                    state_next_s = LOAD_B;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD_B: begin
                load_b       = 1'b1;
                state_next_s = RUN;
            end
            RUN: begin
                add_en = 1'b1;
                if (last_s) begin
                    state_next_s = FIXUP;
                end else begin
                    state_next_s = RUN;
                end
            end
            FIXUP: begin
                fix_en       = 1'b1;
                out_sel      = SEL_LO;
                state_next_s = OUT_LO;
            end
            OUT_LO: begin
                out_sel      = SEL_HI;
                state_next_s = OUT_HI;
            end
            OUT_HI: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, busy flag and RUN counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
            if (load_b) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (add_en) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign busy = busy_r;
    assign cnt  = cnt_r;

endmodule

// File: rtl/seq_mult_bus.sv
// Sequential shift-add multiplier fed and read back over the shared Z bus.
// Operands are reduced to magnitudes on entry; the sign is re-applied in FIXUP.
module seq_mult_bus
    import seq_mult_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    seq_mult_bus_if.slave   bus
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam int PW    = 2 * WIDTH;

    // Two's-complement magnitude; -2^(W-1) maps to 2^(W-1), which still fits unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic neg);
        logic [WIDTH-1:0] r;
        if (neg) begin
            r = {WIDTH{1'b0}} - x;
        end else begin
            r = x;
        end
        return r;
    endfunction

    logic             load_a_s;
    logic             load_b_s;
    logic             add_en_s;
    logic             fix_en_s;
    out_sel_t         out_sel_s;
    logic             busy_s;
    logic [CNT_W-1:0] cnt_s;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [PW-1:0]    p_r;
    logic             sa_r;
    logic             sb_r;
    logic             mode_r;
    logic [WIDTH-1:0] z_out_r;
    logic             z_oe_r;
    logic             done_r;

    logic             mode_in_s;
    logic             sign_a_s;
    logic             sign_b_s;
    logic [PW-1:0]    p_add_s;
    logic [PW-1:0]    p_fix_s;

    seq_mult_fsm #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_fsm (
        .clk     (clk),
        .rst     (rst),
        .start   (bus.start),
        .b       (b_r),
        .load_a  (load_a_s),
        .load_b  (load_b_s),
        .add_en  (add_en_s),
        .fix_en  (fix_en_s),
        .out_sel (out_sel_s),
        .busy    (busy_s),
        .cnt     (cnt_s)
    );

    // Operand sign decode, partial-product accumulate and final sign correction.
    always_comb begin
        mode_in_s = bus.signed_mode & SIGNED_EN;
        sign_a_s  = mode_in_s & bus.z_in[WIDTH-1];
        sign_b_s  = mode_r & bus.z_in[WIDTH-1];
        if (b_r[0]) begin
            p_add_s = p_r + ({{WIDTH{1'b0}}, a_r} << cnt_s);
        end else begin
            p_add_s = p_r;
        end
        if (mode_r && (sa_r ^ sb_r)) begin
            p_fix_s = {PW{1'b0}} - p_r;
        end else begin
            p_fix_s = p_r;
        end
    end

    // Multiplicand magnitude, its sign and the operating mode, captured on start.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= {WIDTH{1'b0}};
            sa_r   <= 1'b0;
            mode_r <= 1'b0;
        end else if (load_a_s) begin
            a_r    <= magnitude(bus.z_in, sign_a_s);
            sa_r   <= sign_a_s;
            mode_r <= mode_in_s;
        end else begin
            a_r    <= a_r;
            sa_r   <= sa_r;
            mode_r <= mode_r;
        end
    end

    // Multiplier shift register and product accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_r  <= {WIDTH{1'b0}};
            sb_r <= 1'b0;
            p_r  <= {PW{1'b0}};
        end else if (load_b_s) begin
            b_r  <= magnitude(bus.z_in, sign_b_s);
            sb_r <= sign_b_s;
            p_r  <= {PW{1'b0}};
        end else if (add_en_s) begin
            b_r  <= b_r >> 1;
            sb_r <= sb_r;
            p_r  <= p_add_s;
        end else if (fix_en_s) begin
            b_r  <= b_r;
            sb_r <= sb_r;
            p_r  <= p_fix_s;
        end else begin
            b_r  <= b_r;
            sb_r <= sb_r;
            p_r  <= p_r;
        end
    end

    // Registered bus drive: lo word with done, then hi word, otherwise released.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_out_r <= {WIDTH{1'b0}};
            z_oe_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (out_sel_s)
                SEL_LO: begin
                    z_out_r <= p_fix_s[WIDTH-1:0];
                    z_oe_r  <= 1'b1;
                    done_r  <= 1'b1;
                end
                SEL_HI: begin
                    z_out_r <= p_r[PW-1:WIDTH];
                    z_oe_r  <= 1'b1;
                    done_r  <= 1'b0;
                end
                default: begin
                    z_out_r <= {WIDTH{1'b0}};
                    z_oe_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.z_out = z_out_r;
    assign bus.z_oe  = z_oe_r;
    assign bus.a     = a_r;
    assign bus.b     = b_r;
    assign bus.busy  = busy_s;
    assign bus.done  = done_r;

endmodule

// File: tb/tb_seq_mult_bus.sv
// Scoreboard bench for seq_mult_bus: a 32-bit signed-capable instance and an 8-bit unsigned-only one.
module tb_seq_mult_bus;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_mult_bus_if #(.WIDTH(32)) bus32 ();
    seq_mult_bus_if #(.WIDTH(8))  bus8 ();

    seq_mult_bus #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    seq_mult_bus #(.WIDTH(8),  .SIGNED_EN(1'b0)) dut8  (.clk(clk), .rst(rst), .bus(bus8));

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        int          k;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic get_obs(input bit w8, output logic [31:0] zo, output logic [31:0] av,
                           output logic [31:0] bv, output logic oe, output logic dn, output logic bsy);
        if (w8) begin
            zo = {24'd0, bus8.z_out}; av = {24'd0, bus8.a}; bv = {24'd0, bus8.b};
            oe = bus8.z_oe; dn = bus8.done; bsy = bus8.busy;
        end else begin
            zo = bus32.z_out; av = bus32.a; bv = bus32.b;
            oe = bus32.z_oe; dn = bus32.done; bsy = bus32.busy;
        end
    endtask

    task automatic drive(input bit w8, input logic st, input logic md, input logic [31:0] z);
        if (w8) begin
            bus8.start = st; bus8.signed_mode = md; bus8.z_in = z[7:0];
        end else begin
            bus32.start = st; bus32.signed_mode = md; bus32.z_in = z;
        end
    endtask

    // Reference model: plain multiplication, magnitudes and RUN length from the multiplier magnitude.
    task automatic push_exp(input bit w8, input logic [31:0] a_in, input logic [31:0] b_in, input bit mode);
        exp_t        e;
        logic [63:0] p;
        longint      la;
        longint      lb;
        int          w;
        if (w8) begin
            w       = 8;
            p       = {56'd0, a_in[7:0]} * {56'd0, b_in[7:0]};
            e.lo    = {24'd0, p[7:0]};
            e.hi    = {24'd0, p[15:8]};
            e.mag_a = {24'd0, a_in[7:0]};
            e.mag_b = {24'd0, b_in[7:0]};
        end else begin
            w = 32;
            if (mode) begin
                la      = $signed(a_in);
                lb      = $signed(b_in);
                p       = la * lb;
                e.mag_a = (la < 0) ? 32'(-la) : a_in;
                e.mag_b = (lb < 0) ? 32'(-lb) : b_in;
            end else begin
                p       = {32'd0, a_in} * {32'd0, b_in};
                e.mag_a = a_in;
                e.mag_b = b_in;
            end
            e.lo = p[31:0];
            e.hi = p[63:32];
        end
        e.k = 1;
        for (int i = 0; i < w; i++) begin
            if (e.mag_b[i]) e.k = i + 1;
        end
        sb_q.push_back(e);
    endtask

    // One full operation; poke pulses start while busy and again in the OUT_HI cycle.
    task automatic run_op(input bit w8, input logic [31:0] a_in, input logic [31:0] b_in,
                          input bit mode, input bit poke);
        exp_t        e;
        logic [31:0] zo, av, bv;
        logic        oe, dn, bsy;
        int          done_at;
        int          oe_n;
        int          dn_n;
        int          k;
        logic [31:0] hi_exp;
        push_exp(w8, a_in, b_in, mode);
        k       = sb_q[$].k;
        done_at = -1;
        oe_n    = 0;
        dn_n    = 0;
        hi_exp  = 32'd0;
        @(negedge clk);
        drive(w8, 1'b1, mode, a_in);
        @(posedge clk);
        #1;
        drive(w8, 1'b0, mode, b_in);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            drive(w8, poke && (c == 3 || c == k + 3), ~mode, $urandom);
            get_obs(w8, zo, av, bv, oe, dn, bsy);
            if (c == 1) begin
                check_val("a_loaded", {32'd0, av}, {32'd0, sb_q[$].mag_a});
                check_val("b_loaded", {32'd0, bv}, {32'd0, sb_q[$].mag_b});
                check_val("busy_run", {63'd0, bsy}, 64'd1);
            end
            if (oe) oe_n++;
            if (dn) dn_n++;
            if (dn && done_at < 0) begin
                done_at = c;
                if (sb_q.size() == 0) begin
                    check_val("sb_nonempty", 64'd0, 64'd1);
                end else begin
                    e = sb_q.pop_front();
                    check_val("lo_word", {32'd0, zo}, {32'd0, e.lo});
                    check_val("a_held", {32'd0, av}, {32'd0, e.mag_a});
                    hi_exp = e.hi;
                end
            end else if (done_at > 0 && c == done_at + 1) begin
                check_val("hi_word", {32'd0, zo}, {32'd0, hi_exp});
                check_val("hi_oe", {63'd0, oe}, 64'd1);
            end
        end
        drive(w8, 1'b0, 1'b0, 32'd0);
        check_val("done_cycle", 64'(done_at), 64'(k + 2));
        check_val("oe_cycles", 64'(oe_n), 64'd2);
        check_val("done_cycles", 64'(dn_n), 64'd1);
        get_obs(w8, zo, av, bv, oe, dn, bsy);
        check_val("idle_busy", {63'd0, bsy}, 64'd0);
    endtask

    // Operation aborted by reset in the middle of RUN.
    task automatic reset_mid_run();
        logic [31:0] zo, av, bv;
        logic        oe, dn, bsy;
        int          dn_n;
        dn_n = 0;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h0000_1234);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        repeat (5) @(posedge clk);
        #1;
        get_obs(1'b0, zo, av, bv, oe, dn, bsy);
        check_val("busy_before_rst", {63'd0, bsy}, 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        get_obs(1'b0, zo, av, bv, oe, dn, bsy);
        check_val("rst_busy", {63'd0, bsy}, 64'd0);
        check_val("rst_oe", {63'd0, oe}, 64'd0);
        check_val("rst_done", {63'd0, dn}, 64'd0);
        check_val("rst_a", {32'd0, av}, 64'd0);
        check_val("rst_b", {32'd0, bv}, 64'd0);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            get_obs(1'b0, zo, av, bv, oe, dn, bsy);
            if (dn || oe) dn_n++;
        end
        check_val("no_done_after_rst", 64'(dn_n), 64'd0);
    endtask

    initial begin
        logic [31:0] zo, av, bv;
        logic        oe, dn, bsy;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            get_obs(w[0], zo, av, bv, oe, dn, bsy);
            check_val("reset_state", {zo, av ^ bv, 29'd0, oe, dn, bsy}, 64'd0);
        end
        rst = 1'b0;

        run_op(1'b0, 32'h0000_0F0F, 32'h0000_F0F0, 1'b0, 1'b0);
        run_op(1'b0, 32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 1'b0);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_op(1'b0, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b1);
        run_op(1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 1'b1);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, $urandom, $urandom, i[0], i[1]);
        end

        reset_mid_run();
        run_op(1'b0, 32'h0000_0F0F, 32'h0000_F0F0, 1'b0, 1'b0);

        run_op(1'b1, 32'h0000_00FF, 32'h0000_00FF, 1'b1, 1'b0);
        run_op(1'b1, 32'h0000_0080, 32'h0000_0003, 1'b1, 1'b1);
        run_op(1'b1, 32'h0000_0055, 32'h0000_0000, 1'b0, 1'b0);

        check_val("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
